// File: rtl/ysyx_041514_wb_arbiter_pkg.sv
// ysyx_041514_wb_arbiter_pkg
//   Shared widths, the writeback entry record and the arbiter state encoding
//   used by the writeback arbiter and its MDU holding register.
package ysyx_041514_wb_arbiter_pkg;

  localparam int XLEN      = 64;
  localparam int INST_LEN  = 32;
  localparam int REG_ADDRW = 5;

  // One instruction's worth of writeback/commit information.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic [REG_ADDRW-1:0] rd;
    logic                 wen;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  // IDLE: holding register empty. HOLD: one MDU result waiting for a grant.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // A granted entry only writes the regfile when it asks to and rd is not x0.
  function automatic logic gpr_write_en(input wb_entry_t e);
    return e.wen && (e.rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_041514_wb_holdreg.sv
// ysyx_041514_wb_holdreg
//   Single-entry holding register for MDU results.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     i_push, i_entry : load i_entry (only legal while o_ready)
//     i_pop           : release the held entry (only legal while o_valid)
//     o_valid         : an entry is held
//     o_ready         : register is empty and can accept a push
//     o_entry         : the held entry
module ysyx_041514_wb_holdreg
  import ysyx_041514_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output logic      o_valid,
  output logic      o_ready,
  output wb_entry_t o_entry
);

  logic      r_valid;
  wb_entry_t r_entry;

  // Ready is not a function of pop: a new result never overwrites an
  // entry in the same cycle it leaves, which keeps capture-to-write at
  // two cycles minimum and avoids any bypass path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ready = !r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/ysyx_041514_wb_arbiter.sv
// ysyx_041514_wb_arbiter
//   Shares the GPR write port and the commit channel between the in-order
//   MEM/WB stage and the multiply/divide unit. The pipe wins by default; a
//   buffered MDU result may lose at most STARVE_LIMIT consecutive times.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     pipe_*_i / pipe_ready_o  : pipeline writeback entry and its handshake
//     mdu_*_i  / mdu_ready_o   : MDU result and its handshake
//     gpr_*_o                  : registered regfile write port
//     commit_*_o               : registered commit record (pc/inst 0 if none)
//     mdu_pending_o            : MDU result held, for the hazard unit
//     dbg_state_o, dbg_starve_cnt_o : arbiter FSM state and starvation count
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   Valid must not depend on ready; ready may depend on valid/state.
module ysyx_041514_wb_arbiter
  import ysyx_041514_wb_arbiter_pkg::*;
#(
  parameter  int STARVE_LIMIT = 4,
  localparam int CNTW         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid_i,
  output logic                 pipe_ready_o,
  input  logic [XLEN-1:0]      pipe_pc_i,
  input  logic [INST_LEN-1:0]  pipe_inst_i,
  input  logic [REG_ADDRW-1:0] pipe_rd_i,
  input  logic                 pipe_wen_i,
  input  logic [XLEN-1:0]      pipe_data_i,
  input  logic                 mdu_valid_i,
  output logic                 mdu_ready_o,
  input  logic [XLEN-1:0]      mdu_pc_i,
  input  logic [INST_LEN-1:0]  mdu_inst_i,
  input  logic [REG_ADDRW-1:0] mdu_rd_i,
  input  logic [XLEN-1:0]      mdu_data_i,
  output logic                 gpr_wen_o,
  output logic [REG_ADDRW-1:0] gpr_waddr_o,
  output logic [XLEN-1:0]      gpr_wdata_o,
  output logic                 commit_valid_o,
  output logic [XLEN-1:0]      commit_pc_o,
  output logic [INST_LEN-1:0]  commit_inst_o,
  output logic                 mdu_pending_o,
  output arb_state_e           dbg_state_o,
  output logic [CNTW-1:0]      dbg_starve_cnt_o
);

  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  arb_state_e      r_state;
  arb_state_e      w_state_next;
  logic [CNTW-1:0] r_starve_cnt;
  logic [CNTW-1:0] w_starve_next;

  logic            w_hold_valid;
  logic            w_hold_ready;
  wb_entry_t       w_hold_entry;
  wb_entry_t       w_mdu_entry;
  wb_entry_t       w_pipe_entry;
  wb_entry_t       w_sel_entry;
  logic            w_mdu_push;
  logic            w_pipe_grant;
  logic            w_mdu_grant;
  logic            w_at_limit;

  assign w_pipe_entry = '{pc: pipe_pc_i, inst: pipe_inst_i, rd: pipe_rd_i,
                          wen: pipe_wen_i, data: pipe_data_i};
  // MDU results always target a GPR.
  assign w_mdu_entry  = '{pc: mdu_pc_i, inst: mdu_inst_i, rd: mdu_rd_i,
                          wen: 1'b1, data: mdu_data_i};

  assign w_mdu_push   = mdu_valid_i && w_hold_ready;

  ysyx_041514_wb_holdreg u_holdreg (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_mdu_push),
    .i_entry (w_mdu_entry),
    .i_pop   (w_mdu_grant),
    .o_valid (w_hold_valid),
    .o_ready (w_hold_ready),
    .o_entry (w_hold_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // HOLD tracks exactly when the holding register is occupied. The pipe is
  // refused only when the held MDU result has used up its losses; that
  // refusal depends on registered state alone, never on pipe_valid_i.
  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    w_at_limit    = (r_state == ARB_HOLD) && (r_starve_cnt == LIMIT);
    pipe_ready_o  = !w_at_limit;
    w_pipe_grant  = pipe_valid_i && !w_at_limit;
    w_mdu_grant   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_mdu_push) w_state_next = ARB_HOLD;
      end
      ARB_HOLD: begin
        w_mdu_grant = !w_pipe_grant;
        if (w_mdu_grant) begin
          w_starve_next = '0;
          w_state_next  = ARB_IDLE;
        end else if (r_starve_cnt != LIMIT) begin
          w_starve_next = r_starve_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_next  = ARB_IDLE;
        w_starve_next = '0;
      end
    endcase
  end

  assign w_sel_entry = w_pipe_grant ? w_pipe_entry : w_hold_entry;

  // Write address/data only change on a grant so the regfile sees a
  // stable bus between writes; enable and commit fields return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wen_o      <= 1'b0;
      gpr_waddr_o    <= '0;
      gpr_wdata_o    <= '0;
      commit_valid_o <= 1'b0;
      commit_pc_o    <= '0;
      commit_inst_o  <= '0;
    end else if (w_pipe_grant || w_mdu_grant) begin
      gpr_wen_o      <= gpr_write_en(w_sel_entry);
      gpr_waddr_o    <= w_sel_entry.rd;
      gpr_wdata_o    <= w_sel_entry.data;
      commit_valid_o <= 1'b1;
      commit_pc_o    <= w_sel_entry.pc;
      commit_inst_o  <= w_sel_entry.inst;
    end else begin
      gpr_wen_o      <= 1'b0;
      commit_valid_o <= 1'b0;
      commit_pc_o    <= '0;
      commit_inst_o  <= '0;
    end
  end

  assign mdu_ready_o      = w_hold_ready;
  assign mdu_pending_o    = w_hold_valid;
  assign dbg_state_o      = r_state;
  assign dbg_starve_cnt_o = r_starve_cnt;

endmodule
